// File: rtl/bsg_mem_2rw_sync_mask_write_bit_req_ctrl.sv
// Purpose: valid/ready front end for a 2-port bit-masked sync RAM with same-address arbitration.
// Latency: requests reach the RAM combinationally; read responses appear 1 cycle after fire.
// Backpressure: a port stops accepting requests while its response is unconsumed (yumi frees it same cycle).
module bsg_mem_2rw_sync_mask_write_bit_req_ctrl #(
  parameter int width_p                = 8,
  parameter int els_p                  = 16,
  parameter int read_write_same_addr_p = 0,
  parameter int addr_width_lp          = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,

  input  logic                     a_v_i,
  input  logic                     a_w_i,
  input  logic [addr_width_lp-1:0] a_addr_i,
  input  logic [width_p-1:0]       a_data_i,
  input  logic [width_p-1:0]       a_w_mask_i,
  output logic                     a_ready_o,
  output logic [width_p-1:0]       a_data_o,
  output logic                     a_v_o,
  input  logic                     a_yumi_i,

  input  logic                     b_v_i,
  input  logic                     b_w_i,
  input  logic [addr_width_lp-1:0] b_addr_i,
  input  logic [width_p-1:0]       b_data_i,
  input  logic [width_p-1:0]       b_w_mask_i,
  output logic                     b_ready_o,
  output logic [width_p-1:0]       b_data_o,
  output logic                     b_v_o,
  input  logic                     b_yumi_i,

  output logic                     mem_a_v_o,
  output logic                     mem_a_w_o,
  output logic [addr_width_lp-1:0] mem_a_addr_o,
  output logic [width_p-1:0]       mem_a_data_o,
  output logic [width_p-1:0]       mem_a_w_mask_o,
  input  logic [width_p-1:0]       mem_a_data_i,

  output logic                     mem_b_v_o,
  output logic                     mem_b_w_o,
  output logic [addr_width_lp-1:0] mem_b_addr_o,
  output logic [width_p-1:0]       mem_b_data_o,
  output logic [width_p-1:0]       mem_b_w_mask_o,
  input  logic [width_p-1:0]       mem_b_data_i
);

  localparam bit rw_same_lp = (read_write_same_addr_p != 0);

  logic               collision;
  logic               a_lose, b_lose;
  logic               a_slot_free, b_slot_free;
  logic               a_fire, b_fire;

  logic               a_inflight_q, a_inflight_d;
  logic               b_inflight_q, b_inflight_d;
  logic               a_hold_v_q, a_hold_v_d;
  logic               b_hold_v_q, b_hold_v_d;
  logic [width_p-1:0] a_hold_data_q, a_hold_data_d;
  logic [width_p-1:0] b_hold_data_q, b_hold_data_d;
  logic               prio_b_q, prio_b_d;

  // Same-address pairs the RAM cannot service in one cycle; write-write always conflicts
  always_comb begin
    collision = a_v_i & b_v_i & (a_addr_i == b_addr_i) & (a_w_i | b_w_i)
              & (~rw_same_lp | (a_w_i & b_w_i));
  end

  assign a_lose = collision &  prio_b_q;
  assign b_lose = collision & ~prio_b_q;

  // A port may take a new request only if its response slot is empty or being emptied now
  assign a_v_o       = a_inflight_q | a_hold_v_q;
  assign b_v_o       = b_inflight_q | b_hold_v_q;
  assign a_slot_free = ~a_v_o | a_yumi_i;
  assign b_slot_free = ~b_v_o | b_yumi_i;
  assign a_ready_o   = a_slot_free & ~a_lose;
  assign b_ready_o   = b_slot_free & ~b_lose;
  assign a_fire      = a_v_i & a_ready_o;
  assign b_fire      = b_v_i & b_ready_o;

  // Held data wins; otherwise the RAM output is live for the cycle after the read
  assign a_data_o = a_hold_v_q ? a_hold_data_q : mem_a_data_i;
  assign b_data_o = b_hold_v_q ? b_hold_data_q : mem_b_data_i;

  assign mem_a_v_o      = a_fire;
  assign mem_a_w_o      = a_w_i;
  assign mem_a_addr_o   = a_addr_i;
  assign mem_a_data_o   = a_data_i;
  assign mem_a_w_mask_o = a_w_mask_i;
  assign mem_b_v_o      = b_fire;
  assign mem_b_w_o      = b_w_i;
  assign mem_b_addr_o   = b_addr_i;
  assign mem_b_data_o   = b_data_i;
  assign mem_b_w_mask_o = b_w_mask_i;

  // Next-state for response tracking and the priority toggle
  always_comb begin
    a_inflight_d  = a_fire & ~a_w_i;
    b_inflight_d  = b_fire & ~b_w_i;
    a_hold_v_d    = a_hold_v_q;
    a_hold_data_d = a_hold_data_q;
    b_hold_v_d    = b_hold_v_q;
    b_hold_data_d = b_hold_data_q;
    // Capture the RAM output if unconsumed, since a later access may change it
    if (a_inflight_q & ~a_yumi_i) begin
      a_hold_v_d    = 1'b1;
      a_hold_data_d = mem_a_data_i;
    end else if (a_hold_v_q & a_yumi_i) begin
      a_hold_v_d    = 1'b0;
    end
    if (b_inflight_q & ~b_yumi_i) begin
      b_hold_v_d    = 1'b1;
      b_hold_data_d = mem_b_data_i;
    end else if (b_hold_v_q & b_yumi_i) begin
      b_hold_v_d    = 1'b0;
    end
    // B gets priority after losing once, and gives it back as soon as it fires
    prio_b_d = prio_b_q;
    if (b_lose)      prio_b_d = 1'b1;
    else if (b_fire) prio_b_d = 1'b0;
  end

  // State registers, cleared asynchronously so responses vanish immediately on reset
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      a_inflight_q  <= 1'b0;
      b_inflight_q  <= 1'b0;
      a_hold_v_q    <= 1'b0;
      b_hold_v_q    <= 1'b0;
      a_hold_data_q <= '0;
      b_hold_data_q <= '0;
      prio_b_q      <= 1'b0;
    end else begin
      a_inflight_q  <= a_inflight_d;
      b_inflight_q  <= b_inflight_d;
      a_hold_v_q    <= a_hold_v_d;
      b_hold_v_q    <= b_hold_v_d;
      a_hold_data_q <= a_hold_data_d;
      b_hold_data_q <= b_hold_data_d;
      prio_b_q      <= prio_b_d;
    end
  end

`ifndef SYNTHESIS
  a_yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i) a_yumi_i |-> a_v_o);
  b_yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i) b_yumi_i |-> b_v_o);
  a_v_in_reset: assert property (@(posedge clk_i) !reset_n_i |-> !a_v_o);
  b_v_in_reset: assert property (@(posedge clk_i) !reset_n_i |-> !b_v_o);
`endif

endmodule

// File: tb/tb_bsg_mem_2rw_sync_mask_write_bit_req_ctrl.sv
module tb_bsg_mem_2rw_sync_mask_write_bit_req_ctrl;

  localparam int W   = 8;
  localparam int ELS = 16;
  localparam int AW  = 4;
  localparam int RWS = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          a_v, a_w, a_yumi, b_v, b_w, b_yumi;
  logic [AW-1:0] a_addr, b_addr;
  logic [W-1:0]  a_data, a_mask, b_data, b_mask;

  logic          a_ready_o, a_v_o, b_ready_o, b_v_o;
  logic [W-1:0]  a_data_o, b_data_o;
  logic          mem_a_v_o, mem_a_w_o, mem_b_v_o, mem_b_w_o;
  logic [AW-1:0] mem_a_addr_o, mem_b_addr_o;
  logic [W-1:0]  mem_a_data_o, mem_a_w_mask_o, mem_b_data_o, mem_b_w_mask_o;
  logic [W-1:0]  mem_a_data, mem_b_data;

  bsg_mem_2rw_sync_mask_write_bit_req_ctrl #(
    .width_p(W), .els_p(ELS), .read_write_same_addr_p(RWS)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .a_v_i(a_v), .a_w_i(a_w), .a_addr_i(a_addr), .a_data_i(a_data), .a_w_mask_i(a_mask),
    .a_ready_o(a_ready_o), .a_data_o(a_data_o), .a_v_o(a_v_o), .a_yumi_i(a_yumi),
    .b_v_i(b_v), .b_w_i(b_w), .b_addr_i(b_addr), .b_data_i(b_data), .b_w_mask_i(b_mask),
    .b_ready_o(b_ready_o), .b_data_o(b_data_o), .b_v_o(b_v_o), .b_yumi_i(b_yumi),
    .mem_a_v_o(mem_a_v_o), .mem_a_w_o(mem_a_w_o), .mem_a_addr_o(mem_a_addr_o),
    .mem_a_data_o(mem_a_data_o), .mem_a_w_mask_o(mem_a_w_mask_o), .mem_a_data_i(mem_a_data),
    .mem_b_v_o(mem_b_v_o), .mem_b_w_o(mem_b_w_o), .mem_b_addr_o(mem_b_addr_o),
    .mem_b_data_o(mem_b_data_o), .mem_b_w_mask_o(mem_b_w_mask_o), .mem_b_data_i(mem_b_data)
  );

  function automatic logic [W-1:0] merge(input logic [W-1:0] old, input logic [W-1:0] d,
                                         input logic [W-1:0] m);
    return (old & ~m) | (d & m);
  endfunction

  // Behavioural RAM: write-first, output is garbage on cycles with no read
  logic [W-1:0] ram [ELS];
  logic [W-1:0] rd_a, rd_b;
  always_comb begin
    rd_a = ram[mem_a_addr_o];
    if (mem_b_v_o && mem_b_w_o && mem_b_addr_o == mem_a_addr_o)
      rd_a = merge(rd_a, mem_b_data_o, mem_b_w_mask_o);
    rd_b = ram[mem_b_addr_o];
    if (mem_a_v_o && mem_a_w_o && mem_a_addr_o == mem_b_addr_o)
      rd_b = merge(rd_b, mem_a_data_o, mem_a_w_mask_o);
  end
  always @(posedge clk) begin
    if (mem_a_v_o && mem_a_w_o) ram[mem_a_addr_o] <= merge(ram[mem_a_addr_o], mem_a_data_o, mem_a_w_mask_o);
    if (mem_b_v_o && mem_b_w_o) ram[mem_b_addr_o] <= merge(ram[mem_b_addr_o], mem_b_data_o, mem_b_w_mask_o);
    mem_a_data <= (mem_a_v_o && !mem_a_w_o) ? rd_a : W'($urandom);
    mem_b_data <= (mem_b_v_o && !mem_b_w_o) ? rd_b : W'($urandom);
  end

  // Reference model: memory contents, pending responses per port, B-priority flag
  logic [W-1:0] mdl [ELS];
  logic [W-1:0] q_a[$], q_b[$];
  bit  prio_m = 1'b0;
  bit  e_rdy_a, e_rdy_b, e_coll;
  int  nfa = 0, nfb = 0;
  int  vecs = 0, errs = 0;

  task automatic predict();
    e_coll  = a_v && b_v && (a_addr == b_addr) && (a_w || b_w) && (RWS == 0 || (a_w && b_w));
    e_rdy_a = (q_a.size() == 0 || a_yumi) && !(e_coll && prio_m);
    e_rdy_b = (q_b.size() == 0 || b_yumi) && !(e_coll && !prio_m);
  endtask

  task automatic tick();
    bit fa, fb;
    predict();
    fa = a_v && e_rdy_a;
    fb = b_v && e_rdy_b;
    if (a_yumi && q_a.size() != 0) void'(q_a.pop_front());
    if (b_yumi && q_b.size() != 0) void'(q_b.pop_front());
    if (fa && a_w) mdl[a_addr] = merge(mdl[a_addr], a_data, a_mask);
    if (fb && b_w) mdl[b_addr] = merge(mdl[b_addr], b_data, b_mask);
    if (fa && !a_w) q_a.push_back(mdl[a_addr]);
    if (fb && !b_w) q_b.push_back(mdl[b_addr]);
    if (e_coll && !prio_m) prio_m = 1'b1;
    else if (fb) prio_m = 1'b0;
    nfa += int'(fa);
    nfb += int'(fb);
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input bit v, input bit w, input logic [AW-1:0] ad,
                       input logic [W-1:0] d, input logic [W-1:0] m, input bit y);
    a_v = v; a_w = w; a_addr = ad; a_data = d; a_mask = m; a_yumi = y;
  endtask

  task automatic set_b(input bit v, input bit w, input logic [AW-1:0] ad,
                       input logic [W-1:0] d, input logic [W-1:0] m, input bit y);
    b_v = v; b_w = w; b_addr = ad; b_data = d; b_mask = m; b_yumi = y;
  endtask

  task automatic idle();
    set_a(0, 0, '0, '0, '0, 0);
    set_b(0, 0, '0, '0, '0, 0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    vecs++; if (a_v_o !== 1'b0 || b_v_o !== 1'b0) begin errs++;
      $display("FAIL reset_v: a_v_o=%b b_v_o=%b want 0 0", a_v_o, b_v_o); end
    reset_n = 1'b1;
    #1;
    vecs++; if (a_ready_o !== 1'b1 || b_ready_o !== 1'b1) begin errs++;
      $display("FAIL reset_ready: a=%b b=%b want 1 1", a_ready_o, b_ready_o); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < ELS / 2; i++) begin
      set_a(1, 1, AW'(2 * i), W'($urandom), 8'hFF, 0);
      set_b(1, 1, AW'(2 * i + 1), (i == 0) ? 8'h3C : (i == 1) ? 8'hFF : W'($urandom), 8'hFF, 0);
      #1;
      vecs++; if (a_ready_o !== 1'b1 || b_ready_o !== 1'b1) begin errs++;
        $display("FAIL fill_ready[%0d]: a=%b b=%b want 1 1", i, a_ready_o, b_ready_o); end
      vecs++; if (mem_a_v_o !== 1'b1 || mem_a_addr_o !== AW'(2 * i) || mem_b_w_mask_o !== 8'hFF) begin errs++;
        $display("FAIL fill_mem[%0d]: v=%b addr=%h mask=%h", i, mem_a_v_o, mem_a_addr_o, mem_b_w_mask_o); end
      tick();
    end
    idle();
  endtask

  task automatic test_write_then_read();
    set_a(1, 1, 4'd3, 8'hA5, 8'h0F, 0);
    #1;
    vecs++; if (a_ready_o !== 1'b1 || mem_a_w_o !== 1'b1 || mem_a_w_mask_o !== 8'h0F) begin errs++;
      $display("FAIL wr_issue: rdy=%b w=%b mask=%h want 1 1 0f", a_ready_o, mem_a_w_o, mem_a_w_mask_o); end
    tick();
    set_a(1, 0, 4'd3, 8'h00, 8'h00, 0);
    #1;
    vecs++; if (a_v_o !== 1'b0 || a_ready_o !== 1'b1) begin errs++;
      $display("FAIL wr_no_resp: v_o=%b rdy=%b want 0 1", a_v_o, a_ready_o); end
    tick();
    set_a(0, 0, '0, '0, '0, 1);
    #1;
    vecs++; if (a_v_o !== 1'b1 || a_data_o !== 8'hF5) begin errs++;
      $display("FAIL rd_after_wr: v_o=%b data=%h want 1 f5", a_v_o, a_data_o); end
    tick();
    idle();
    #1;
    vecs++; if (a_v_o !== 1'b0) begin errs++;
      $display("FAIL rd_consumed: v_o=%b want 0", a_v_o); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] old, nxt;
    old = mdl[1];
    set_a(1, 0, 4'd1, '0, '0, 0);
    #1;
    tick();
    for (int k = 0; k < 3; k++) begin
      set_a(1, 0, 4'd2, '0, '0, 0);
      set_b(1, 1, 4'd1, W'($urandom), 8'hFF, 0);
      #1;
      vecs++; if (a_v_o !== 1'b1 || a_data_o !== old) begin errs++;
        $display("FAIL bp_hold[%0d]: v_o=%b data=%h want 1 %h", k, a_v_o, a_data_o, old); end
      vecs++; if (a_ready_o !== 1'b0 || b_ready_o !== 1'b1) begin errs++;
        $display("FAIL bp_ready[%0d]: a=%b b=%b want 0 1", k, a_ready_o, b_ready_o); end
      tick();
    end
    set_b(0, 0, '0, '0, '0, 0);
    set_a(1, 0, 4'd2, '0, '0, 1);
    #1;
    vecs++; if (a_ready_o !== 1'b1 || a_data_o !== old) begin errs++;
      $display("FAIL bp_release: rdy=%b data=%h want 1 %h", a_ready_o, a_data_o, old); end
    nxt = mdl[2];
    tick();
    set_a(0, 0, '0, '0, '0, 1);
    #1;
    vecs++; if (a_v_o !== 1'b1 || a_data_o !== nxt) begin errs++;
      $display("FAIL bp_next: v_o=%b data=%h want 1 %h", a_v_o, a_data_o, nxt); end
    tick();
    idle();
  endtask

  task automatic test_collision();
    logic [W-1:0] d, want;
    d = W'($urandom);
    want = merge(mdl[5], d, 8'hFF);
    set_a(1, 1, 4'd5, d, 8'hFF, 0);
    set_b(1, 0, 4'd5, '0, '0, 0);
    #1;
    vecs++; if (b_ready_o !== 1'b0 || a_ready_o !== 1'b1 || mem_b_v_o !== 1'b0) begin errs++;
      $display("FAIL coll_c0: a=%b b=%b mem_b_v=%b want 1 0 0", a_ready_o, b_ready_o, mem_b_v_o); end
    tick();
    set_a(0, 0, '0, '0, '0, 0);
    #1;
    vecs++; if (b_ready_o !== 1'b1) begin errs++;
      $display("FAIL coll_c1: b_ready=%b want 1", b_ready_o); end
    tick();
    set_b(0, 0, '0, '0, '0, 1);
    #1;
    vecs++; if (b_v_o !== 1'b1 || b_data_o !== want) begin errs++;
      $display("FAIL coll_data: v_o=%b data=%h want 1 %h", b_v_o, b_data_o, want); end
    tick();
    idle();
  endtask

  task automatic test_fairness();
    logic [W-1:0] last;
    bit ea;
    last = '0;
    for (int i = 0; i < 6; i++) begin
      ea = (i % 2 == 0);
      set_a(1, 1, 4'd7, W'($urandom), 8'hFF, 0);
      set_b(1, 1, 4'd7, W'($urandom), 8'hFF, 0);
      #1;
      vecs++; if (a_ready_o !== ea || b_ready_o !== !ea) begin errs++;
        $display("FAIL fair[%0d]: a=%b b=%b want %b %b", i, a_ready_o, b_ready_o, ea, !ea); end
      last = ea ? a_data : b_data;
      tick();
    end
    set_b(0, 0, '0, '0, '0, 0);
    set_a(1, 0, 4'd7, '0, '0, 0);
    #1;
    tick();
    set_a(0, 0, '0, '0, '0, 1);
    #1;
    vecs++; if (a_v_o !== 1'b1 || a_data_o !== last) begin errs++;
      $display("FAIL fair_final: v_o=%b data=%h want 1 %h", a_v_o, a_data_o, last); end
    tick();
    idle();
  endtask

  task automatic test_streaming();
    int cyc = 0;
    nfa = 0;
    nfb = 0;
    while ((nfa < 100 || nfb < 100) && cyc < 3000) begin
      set_a($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 3)),
            W'($urandom), W'($urandom), q_a.size() != 0 && $urandom_range(0, 3) != 0);
      set_b($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 3)),
            W'($urandom), W'($urandom), q_b.size() != 0 && $urandom_range(0, 3) != 0);
      #1;
      predict();
      vecs++; if (a_ready_o !== e_rdy_a || b_ready_o !== e_rdy_b) begin errs++;
        $display("FAIL stream_ready@%0d: a=%b b=%b want %b %b", cyc, a_ready_o, b_ready_o, e_rdy_a, e_rdy_b); end
      vecs++; if (a_v_o !== (q_a.size() != 0) || b_v_o !== (q_b.size() != 0)) begin errs++;
        $display("FAIL stream_v@%0d: a=%b b=%b want %0d %0d", cyc, a_v_o, b_v_o, q_a.size(), q_b.size()); end
      if (q_a.size() != 0) begin
        vecs++; if (a_data_o !== q_a[0]) begin errs++;
          $display("FAIL stream_a_data@%0d: got %h want %h", cyc, a_data_o, q_a[0]); end
      end
      if (q_b.size() != 0) begin
        vecs++; if (b_data_o !== q_b[0]) begin errs++;
          $display("FAIL stream_b_data@%0d: got %h want %h", cyc, b_data_o, q_b[0]); end
      end
      vecs++; if (mem_a_v_o !== (a_v && e_rdy_a) || mem_b_v_o !== (b_v && e_rdy_b)) begin errs++;
        $display("FAIL stream_mem_v@%0d: a=%b b=%b", cyc, mem_a_v_o, mem_b_v_o); end
      tick();
      cyc++;
    end
    vecs++; if (nfa < 100 || nfb < 100) begin errs++;
      $display("FAIL stream_budget: fires a=%0d b=%0d want >=100 each", nfa, nfb); end
    set_a(0, 0, '0, '0, '0, q_a.size() != 0);
    set_b(0, 0, '0, '0, '0, q_b.size() != 0);
    #1;
    tick();
    idle();
    #1;
    vecs++; if (a_v_o !== 1'b0 || b_v_o !== 1'b0 || q_a.size() != 0 || q_b.size() != 0) begin errs++;
      $display("FAIL stream_drain: a_v=%b b_v=%b", a_v_o, b_v_o); end
  endtask

  task automatic test_reset_midstream();
    set_a(1, 0, 4'd0, '0, '0, 0);
    #1;
    tick();
    idle();
    #1;
    vecs++; if (a_v_o !== 1'b1) begin errs++;
      $display("FAIL mid_pre: a_v_o=%b want 1", a_v_o); end
    reset_n = 1'b0;
    #1;
    vecs++; if (a_v_o !== 1'b0 || b_v_o !== 1'b0) begin errs++;
      $display("FAIL mid_reset: a_v_o=%b b_v_o=%b want 0 0", a_v_o, b_v_o); end
    q_a.delete();
    q_b.delete();
    prio_m = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    vecs++; if (a_ready_o !== 1'b1 || b_ready_o !== 1'b1) begin errs++;
      $display("FAIL mid_release: a=%b b=%b want 1 1", a_ready_o, b_ready_o); end
    for (int i = 0; i < 2; i++) begin
      tick();
      vecs++; if (a_v_o !== 1'b0 || b_v_o !== 1'b0) begin errs++;
        $display("FAIL mid_spurious[%0d]: a_v=%b b_v=%b want 0 0", i, a_v_o, b_v_o); end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_write_then_read();
    test_backpressure();
    test_collision();
    test_fairness();
    test_streaming();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
